if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  async active-high reset.
REQ-004 freeze  in  1  downstream stall; held instruction SHALL NOT be released while 1.
REQ-005 Br_taken  in  1  branch/flush from EXE stage, sampled every cycle.
REQ-006 Br_Addr  in  32  branch target from EXE stage; bits [1:0] ignored (forced 0).
REQ-007 imem_req  out  1  one-cycle fetch request pulse.
REQ-008 imem_addr  out  32  word-aligned fetch address, valid when imem_req=1.
REQ-009 imem_rvalid  in  1  read data valid; at least 1 cycle after imem_req; one response per request.
REQ-010 imem_rdata  in  32  instruction word, valid with imem_rvalid.
REQ-011 PC  out  32  address of held instruction plus 4.
REQ-012 Instruction  out  32  held instruction word.
REQ-013 valid  out  1  PC/Instruction meaningful; downstream consumes on valid=1 and freeze=0.

Function
REQ-014 SHALL hold an internal fetch pointer pc (32 bit) and a squash flag.
REQ-015 SHALL implement states FETCH, WAIT, HOLD.
REQ-016 FETCH: imem_req=1, imem_addr=pc; next state WAIT.
REQ-017 WAIT: imem_req=0; on imem_rvalid with squash=0: Instruction<=imem_rdata, PC<=pc+4, pc<=pc+4, valid<=1; next state HOLD.
REQ-018 WAIT with imem_rvalid=0: remain in WAIT, outputs unchanged.
REQ-019 HOLD: valid=1; freeze=0 -> next FETCH, valid<=0; freeze=1 -> remain HOLD, outputs stable.
REQ-020 pc+4 SHALL wrap modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-021 Br_taken=1 in any state: pc<={Br_Addr[31:2],2'b00}, valid<=0 next cycle; Br_taken overrides freeze.
REQ-022 Br_taken in FETCH (request issued same cycle): next WAIT with squash<=1.
REQ-023 Br_taken in WAIT with imem_rvalid=0: squash<=1, remain WAIT.
REQ-024 Br_taken in WAIT with imem_rvalid=1: response discarded, squash<=0, next FETCH.
REQ-025 Br_taken in HOLD: next FETCH; held instruction discarded.
REQ-026 WAIT, squash=1, imem_rvalid=1, Br_taken=0: response discarded, squash<=0, next FETCH; Instruction/PC unchanged.
REQ-027 imem_rvalid in FETCH or HOLD SHALL be ignored.
REQ-028 Instruction latency: imem_req to valid = response latency + 1 cycle; no more than one request outstanding.
REQ-029 Back-to-back Br_taken: last target seen before the next FETCH wins.

Reset
REQ-030 rst=1 SHALL immediately force state FETCH, pc=0, squash=0, valid=0, PC=0, Instruction=0.
REQ-031 imem_req SHALL be 0 while rst=1; first request at address 0 in the first cycle after release.
REQ-032 Reset mid-WAIT SHALL abandon the outstanding request; instruction memory shares rst and drops it.

Verification
REQ-033 Reset release, memory latency 1, data 0x20010005 at 0 -> imem_req cycle 0 addr 0; valid=1 cycle 2, Instruction=0x20010005, PC=4; next req addr 4.
REQ-034 freeze=1 for 3 cycles during HOLD -> valid, PC, Instruction stable 3 cycles; no imem_req until freeze=0.
REQ-035 Br_taken=1, Br_Addr=0x00000103 in WAIT (latency 3) -> pending response discarded, valid stays 0, next imem_addr=0x00000100.
REQ-036 Br_taken coincident with imem_rvalid -> no valid pulse; next FETCH at Br_Addr.
REQ-037 pc=0xFFFFFFFC fetched -> PC output 0x00000000, next imem_addr 0x00000000.
REQ-038 rst asserted mid-WAIT -> outputs zero asynchronously; after release imem_addr=0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: issues one fetch at a time and holds the returned
// word until the decode stage takes it. Branches from EXE redirect the pointer.
module if_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        Br_taken,
  input  logic [31:0] Br_Addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] Instruction,
  output logic        valid
);
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_squash;
  logic [31:0] r_pc_out;
  logic [31:0] r_instr;
  logic        r_valid;

  logic [31:0] w_br_tgt;
  logic [31:0] w_pc_inc;

  assign w_br_tgt    = Br_Addr & ~32'h3;
  assign w_pc_inc    = r_pc + 32'd4;
  // Request is gated by rst so nothing is issued while reset is held.
  assign imem_req    = (r_state == S_FETCH) && !rst;
  assign imem_addr   = r_pc;
  assign PC          = r_pc_out;
  assign Instruction = r_instr;
  assign valid       = r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_FETCH;
      r_pc     <= '0;
      r_squash <= 1'b0;
      r_pc_out <= '0;
      r_instr  <= '0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          r_state  <= S_WAIT;
          r_squash <= Br_taken;
          r_valid  <= 1'b0;
          if (Br_taken) r_pc <= w_br_tgt;
        end
        S_WAIT: begin
          if (Br_taken) begin
            r_pc    <= w_br_tgt;
            r_valid <= 1'b0;
            if (imem_rvalid) begin
              r_squash <= 1'b0;
              r_state  <= S_FETCH;
            end else begin
              r_squash <= 1'b1;
            end
          end else if (imem_rvalid) begin
            r_squash <= 1'b0;
            if (r_squash) begin
              r_state <= S_FETCH;
            end else begin
              r_instr  <= imem_rdata;
              r_pc_out <= w_pc_inc;
              r_pc     <= w_pc_inc;
              r_valid  <= 1'b1;
              r_state  <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          // A branch discards the held word even under freeze.
          if (Br_taken) begin
            r_pc    <= w_br_tgt;
            r_valid <= 1'b0;
            r_state <= S_FETCH;
          end else if (!freeze) begin
            r_valid <= 1'b0;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus a randomized run against an
// address-stream reference model, with a variable-latency memory responder.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        Br_taken = 1'b0;
  logic [31:0] Br_Addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] PC;
  logic [31:0] Instruction;
  logic        valid;

  int n_chk = 0;
  int n_fail = 0;

  int          mem_lat = 1;
  bit          mem_rand = 1'b0;
  bit          m_pend = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_addr = '0;

  if_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .Br_taken(Br_taken), .Br_Addr(Br_Addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .PC(PC), .Instruction(Instruction), .valid(valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'd3) ^ 32'h20010005;
  endfunction

  // Memory: one response per request, latency mem_lat (or random 1..3) cycles.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      m_pend = 1'b0;
      imem_rvalid = 1'b0;
    end else begin
      imem_rvalid = 1'b0;
      if (m_pend) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata = memf(m_addr);
          m_pend = 1'b0;
        end
      end
      if (imem_req) begin
        m_pend = 1'b1;
        m_addr = imem_addr;
        m_cnt = mem_rand ? int'($urandom_range(1, 3)) : mem_lat;
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    Br_taken = 1'b0;
    freeze = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    n_chk++;
    if (imem_req !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: req=%b valid=%b, expected 0/0", imem_req, valid);
    end
    n_chk++;
    if (PC !== 32'h0 || Instruction !== 32'h0 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: PC=%h Instr=%h addr=%h, expected all 0", PC, Instruction, imem_addr);
    end
  endtask

  task automatic test_basic();
    mem_rand = 1'b0; mem_lat = 1;
    do_reset();
    cyc();
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL basic_req0: req=%b addr=%h, expected 1/00000000", imem_req, imem_addr);
    end
    cyc();
    n_chk++;
    if (imem_req !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_wait: req=%b valid=%b, expected 0/0", imem_req, valid);
    end
    cyc();
    n_chk++;
    if (valid !== 1'b1 || Instruction !== 32'h20010005 || PC !== 32'h4) begin
      n_fail++;
      $display("FAIL basic_valid: valid=%b Instr=%h PC=%h, expected 1/20010005/00000004", valid, Instruction, PC);
    end
    cyc();
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_req1: req=%b addr=%h valid=%b, expected 1/00000004/0", imem_req, imem_addr, valid);
    end
  endtask

  task automatic test_freeze();
    logic [31:0] pc0, in0;
    mem_rand = 1'b0; mem_lat = 1;
    do_reset();
    cyc(); cyc(); cyc();
    pc0 = PC; in0 = Instruction;
    freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (k == 2) freeze = 1'b0;
      n_chk++;
      if (valid !== 1'b1 || PC !== pc0 || Instruction !== in0 || imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL freeze_hold%0d: valid=%b PC=%h Instr=%h req=%b, expected 1/%h/%h/0", k, valid, PC, Instruction, imem_req, pc0, in0);
      end
    end
    cyc();
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL freeze_release: req=%b addr=%h valid=%b, expected 1/00000004/0", imem_req, imem_addr, valid);
    end
  endtask

  task automatic test_branch_wait();
    bit seen = 1'b0;
    mem_rand = 1'b0; mem_lat = 3;
    do_reset();
    cyc();
    cyc();
    Br_taken = 1'b1; Br_Addr = 32'h00000103;
    cyc();
    Br_taken = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      n_chk++;
      if (valid !== 1'b0) begin
        n_fail++;
        $display("FAIL brwait_valid%0d: valid=%b, expected 0", k, valid);
      end
      if (imem_req === 1'b1) seen = 1'b1;
      else cyc();
    end
    n_chk++;
    if (!seen || imem_addr !== 32'h00000100) begin
      n_fail++;
      $display("FAIL brwait_target: seen=%b addr=%h, expected 1/00000100", seen, imem_addr);
    end
  endtask

  task automatic test_branch_rvalid();
    mem_rand = 1'b0; mem_lat = 1;
    do_reset();
    cyc();
    cyc();
    Br_taken = 1'b1; Br_Addr = 32'h00000041;
    cyc();
    Br_taken = 1'b0;
    n_chk++;
    if (valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h00000040) begin
      n_fail++;
      $display("FAIL brrv: valid=%b req=%b addr=%h, expected 0/1/00000040", valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap();
    mem_rand = 1'b0; mem_lat = 1;
    do_reset();
    cyc();
    Br_taken = 1'b1; Br_Addr = 32'hFFFFFFFE;
    cyc();
    Br_taken = 1'b0;
    cyc();
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFFFFFC) begin
      n_fail++;
      $display("FAIL wrap_req: req=%b addr=%h, expected 1/fffffffc", imem_req, imem_addr);
    end
    cyc();
    cyc();
    n_chk++;
    if (valid !== 1'b1 || PC !== 32'h0 || Instruction !== memf(32'hFFFFFFFC)) begin
      n_fail++;
      $display("FAIL wrap_pc: valid=%b PC=%h Instr=%h, expected 1/00000000/%h", valid, PC, Instruction, memf(32'hFFFFFFFC));
    end
    cyc();
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_next: req=%b addr=%h, expected 1/00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_mid_wait();
    mem_rand = 1'b0; mem_lat = 1;
    do_reset();
    cyc(); cyc(); cyc();
    mem_lat = 3;
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    n_chk++;
    if (valid !== 1'b0 || PC !== 32'h0 || Instruction !== 32'h0 || imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rstwait_async: valid=%b PC=%h Instr=%h req=%b, expected 0/0/0/0", valid, PC, Instruction, imem_req);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_lat = 1;
    cyc();
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL rstwait_req: req=%b addr=%h, expected 1/00000000", imem_req, imem_addr);
    end
    cyc(); cyc();
    n_chk++;
    if (valid !== 1'b1 || Instruction !== 32'h20010005 || PC !== 32'h4) begin
      n_fail++;
      $display("FAIL rstwait_refetch: valid=%b Instr=%h PC=%h, expected 1/20010005/00000004", valid, Instruction, PC);
    end
  endtask

  // Model: the fetch stream is a sequence of addresses; each fetch goes to the
  // last branch target or to the consumed word's address + 4. A word is
  // delivered one cycle after its response unless a branch came in between.
  task automatic test_random();
    logic [31:0] exp_next = '0, last_req = '0, tgt;
    bit br_since = 1'b0, outst = 1'b0, exp_valid = 1'b0, br, fz, nv;
    mem_rand = 1'b1;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cyc();
      n_chk++;
      if (valid !== exp_valid) begin
        n_fail++;
        $display("FAIL rnd_valid @%0d: valid=%b, expected %b", i, valid, exp_valid);
      end
      if (valid === 1'b1) begin
        n_chk++;
        if (Instruction !== memf(last_req) || PC !== last_req + 32'd4) begin
          n_fail++;
          $display("FAIL rnd_data @%0d: Instr=%h PC=%h, expected %h/%h", i, Instruction, PC, memf(last_req), last_req + 32'd4);
        end
      end
      if (imem_rvalid) outst = 1'b0;
      if (imem_req === 1'b1) begin
        n_chk++;
        if (imem_addr !== exp_next || outst || valid === 1'b1) begin
          n_fail++;
          $display("FAIL rnd_req @%0d: addr=%h outst=%b valid=%b, expected %h/0/0", i, imem_addr, outst, valid, exp_next);
        end
        last_req = imem_addr;
        br_since = 1'b0;
        outst = 1'b1;
      end
      br = ($urandom_range(0, 9) == 0);
      fz = ($urandom_range(0, 2) == 0);
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | ($urandom & 32'hF)) : $urandom;
      Br_taken = br; Br_Addr = tgt; freeze = fz;
      nv = (imem_rvalid && !br_since && !br) || (valid === 1'b1 && fz && !br);
      if (valid === 1'b1 && !fz && !br) exp_next = last_req + 32'd4;
      if (br) begin
        exp_next = tgt & ~32'h3;
        br_since = 1'b1;
      end
      exp_valid = nv;
    end
    Br_taken = 1'b0;
    freeze = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_freeze();
    test_branch_wait();
    test_branch_rvalid();
    test_wrap();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
